// File: rtl/fsm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fsm_ctrl_pkg : shared states, defaults and helpers for fsm_seq_ctrl  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fsm_ctrl_pkg;

    localparam int c_cnt_w   = 8;
    localparam int c_timeout = 16;
    localparam int c_run_w   = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_HOLD    = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    // The controlled FSM sees a=1 only while we push it towards, and sit in, its final state.
    function automatic logic drives_a(input state_t s);
        return (s == S_DRIVE) || (s == S_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fsm_seq_ctrl_if : request/status and FSM-side signals of the ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fsm_seq_ctrl_if
    import fsm_ctrl_pkg::*;
#(
    parameter int CNT_W = c_cnt_w,
    parameter int RUN_W = c_run_w
);
    logic             start;
    logic [CNT_W-1:0] hold_cycles;
    logic             busy;
    logic             done;
    logic             err;
    logic [RUN_W-1:0] run_cnt;
    logic             fsm_a;
    logic             fsm_out1;
    logic             fsm_out2;

    modport master (
        output start, hold_cycles, fsm_out1, fsm_out2,
        input  busy, done, err, run_cnt, fsm_a
    );

    modport slave (
        input  start, hold_cycles, fsm_out1, fsm_out2,
        output busy, done, err, run_cnt, fsm_a
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/fsm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fsm_seq_ctrl : drives a, waits for final state, dwells, releases     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fsm_seq_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter int CNT_W   = c_cnt_w,
    parameter int TIMEOUT = c_timeout,
    parameter int RUN_W   = c_run_w
) (
    input wire logic      clk,
    input wire logic      rst,
    fsm_seq_ctrl_if.slave bus
);
    localparam int c_tmr_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [c_tmr_w-1:0] r_timer;
    logic [CNT_W-1:0]   r_hold;
    logic               w_tmo;
    logic               w_hold_last;
    logic               w_busy;
    logic               w_done;
    logic               w_err;
    logic               w_a;
    logic [RUN_W-1:0]   w_run_cnt;

    assign w_tmo       = (r_timer == c_tmr_w'(TIMEOUT - 1));
    // A latched dwell of 0 behaves like 1: HOLD always lasts at least one cycle.
    assign w_hold_last = (r_hold <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && bus.start) begin
                r_hold <= bus.hold_cycles;
            end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - 1'b1;
            end
            // One timer serves both wait phases; any state change restarts it.
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if ((r_state == S_DRIVE) || (r_state == S_RELEASE)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
        w_err  = (r_state == S_ERR);
        w_a    = drives_a(r_state);
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_DRIVE;
            end
            S_DRIVE: begin
                if (bus.fsm_out2)   w_next = S_HOLD;
                else if (w_tmo)     w_next = S_ERR;
            end
            S_HOLD: begin
                if (!bus.fsm_out2)  w_next = S_ERR;
                else if (w_hold_last) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.fsm_out1 && !bus.fsm_out2) w_next = S_DONE;
                else if (w_tmo)     w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    sat_counter #(
        .WIDTH (RUN_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (r_state == S_DONE),
        .count (w_run_cnt)
    );

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.err     = w_err;
    assign bus.fsm_a   = w_a;
    assign bus.run_cnt = w_run_cnt;
endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fsm_seq_ctrl : reactive FSM model, run-level reference, literals  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fsm_seq_ctrl;
    localparam int CNT_W     = 8;
    localparam int TIMEOUT   = 16;
    localparam int RUN_W     = 2;
    localparam int c_run_max = (1 << RUN_W) - 1;

    localparam int P_IDLE = 0, P_DRIVE = 1, P_HOLD = 2, P_RELEASE = 3, P_DONE = 4, P_ERR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fsm_seq_ctrl_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) bus ();

    fsm_seq_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .RUN_W   (RUN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy = 0, n_a = 0, n_done = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Three-state FSM stand-in: 0 idle, 1 intermediate, 2 final.
    // Mode 0 normal, 1 never reaches final, 2 drops final after 3 cycles, 3 sticks in intermediate after a falls.
    int   fsm_mode = 0;
    int   fs = 0;
    int   s2_age = 0;
    logic a_s = 1'b0;

    always @(negedge clk) a_s = bus.fsm_a;

    initial begin
        int prev;
        bus.fsm_out1 = 1'b0;
        bus.fsm_out2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            prev = fs;
            case (fs)
                0: fs = a_s ? 1 : 0;
                1: if (a_s) fs = (fsm_mode == 1) ? 1 : 2;
                   else     fs = (fsm_mode == 3) ? 1 : 0;
                default: begin
                    if (!a_s)                              fs = (fsm_mode == 3) ? 1 : 0;
                    else if (fsm_mode == 2 && s2_age >= 2) fs = 0;
                end
            endcase
            s2_age = (fs == 2 && prev == 2) ? s2_age + 1 : 0;
            bus.fsm_out1 = (fs == 1);
            bus.fsm_out2 = (fs == 2);
        end
    end

    // Reference: phase of the current run plus "cycles still to dwell" and "cycles waited".
    int m_ph = P_IDLE;
    int m_left = 0;
    int m_wait = 0;
    int m_cnt = 0;
    bit m_armed = 0;

    always @(negedge clk) begin
        if (m_armed) begin
            chk("busy",    32'(bus.busy),    32'(m_ph != P_IDLE));
            chk("fsm_a",   32'(bus.fsm_a),   32'(m_ph == P_DRIVE || m_ph == P_HOLD));
            chk("done",    32'(bus.done),    32'(m_ph == P_DONE));
            chk("err",     32'(bus.err),     32'(m_ph == P_ERR));
            chk("run_cnt", 32'(bus.run_cnt), 32'(m_cnt));
        end
        n_busy += int'(bus.busy);
        n_a    += int'(bus.fsm_a);
        n_done += int'(bus.done);
        n_err  += int'(bus.err);

        if (rst) begin
            m_ph = P_IDLE; m_cnt = 0; m_wait = 0; m_left = 0; m_armed = 1;
        end else begin
            case (m_ph)
                P_IDLE: if (bus.start) begin
                    m_ph   = P_DRIVE;
                    m_left = (bus.hold_cycles == 0) ? 1 : int'(bus.hold_cycles);
                    m_wait = 0;
                end
                P_DRIVE: if (bus.fsm_out2) m_ph = P_HOLD;
                    else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) m_ph = P_ERR;
                    end
                P_HOLD: if (!bus.fsm_out2) m_ph = P_ERR;
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_ph = P_RELEASE; m_wait = 0; end
                    end
                P_RELEASE: if (!bus.fsm_out1 && !bus.fsm_out2) m_ph = P_DONE;
                    else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) m_ph = P_ERR;
                    end
                P_DONE: begin
                    if (m_cnt < c_run_max) m_cnt++;
                    m_ph = P_IDLE;
                end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    task automatic clr_counts();
        n_busy = 0; n_a = 0; n_done = 0; n_err = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; optionally re-pulse start while busy at loop index extra.
    task automatic run_one(input int h, input int mode, input int extra);
        bit ended;
        ended = 0;
        fsm_mode = mode;
        clr_counts();
        bus.hold_cycles = CNT_W'(h);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hold_cycles = CNT_W'($urandom);
        for (int i = 0; i < 100; i++) begin
            tick();
            bus.start = (i == extra);
            if (!bus.busy) begin ended = 1; break; end
        end
        bus.start = 1'b0;
        chk("run_terminates", 32'(ended), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        bit ended;
        bus.start = 1'b0;
        bus.hold_cycles = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_err",     32'(bus.err),     32'd0);
        chk("rst_fsm_a",   32'(bus.fsm_a),   32'd0);
        chk("rst_run_cnt", 32'(bus.run_cnt), 32'd0);
        repeat (2) tick();

        run_one(3, 0, -1);
        chk("nom_busy_cycles", 32'(n_busy), 32'd9);
        chk("nom_a_cycles",    32'(n_a),    32'd6);
        chk("nom_done_pulses", 32'(n_done), 32'd1);
        chk("nom_run_cnt",     32'(bus.run_cnt), 32'd1);

        run_one(3, 1, -1);
        chk("tmo_busy_cycles", 32'(n_busy), 32'(TIMEOUT + 1));
        chk("tmo_err_pulses",  32'(n_err),  32'd1);
        chk("tmo_run_cnt",     32'(bus.run_cnt), 32'd1);

        run_one(5, 2, -1);
        chk("loss_busy_cycles", 32'(n_busy), 32'd7);
        chk("loss_err_pulses",  32'(n_err),  32'd1);
        chk("loss_done_pulses", 32'(n_done), 32'd0);

        run_one(0, 0, 1);
        chk("h0_busy_cycles", 32'(n_busy), 32'd7);
        chk("h0_a_cycles",    32'(n_a),    32'd4);
        chk("h0_done_pulses", 32'(n_done), 32'd1);
        chk("h0_run_cnt",     32'(bus.run_cnt), 32'd2);

        run_one(2, 3, -1);
        chk("rel_tmo_busy_cycles", 32'(n_busy), 32'(3 + 2 + TIMEOUT + 1));
        chk("rel_tmo_err_pulses",  32'(n_err),  32'd1);
        fsm_mode = 0;
        repeat (3) tick();

        // start held high: second run begins right after the first returns to idle
        clr_counts();
        ended = 0;
        bus.hold_cycles = CNT_W'(1);
        bus.start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (n_done >= 2) begin ended = 1; break; end
        end
        bus.start = 1'b0;
        repeat (4) tick();
        chk("b2b_reached", 32'(ended), 32'd1);
        chk("b2b_busy_cycles", 32'(n_busy), 32'd14);
        chk("b2b_done_pulses", 32'(n_done), 32'd2);

        repeat (5) run_one(1, 0, -1);
        chk("sat_run_cnt", 32'(bus.run_cnt), 32'(c_run_max));

        bus.hold_cycles = CNT_W'(4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drive_fsm_a",   32'(bus.fsm_a),   32'd0);
        chk("rst_drive_busy",    32'(bus.busy),    32'd0);
        chk("rst_drive_run_cnt", 32'(bus.run_cnt), 32'd0);

        for (int c = 0; c < 500; c++) begin
            tick();
            bus.start = ($urandom_range(0, 2) == 0);
            bus.hold_cycles = CNT_W'($urandom_range(0, 4));
            if (!bus.busy && $urandom_range(0, 5) == 0) fsm_mode = int'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencing controller for the single-input three-state control FSM (input `a`, outputs `out1`/`out2`). On a start request it drives `a` high, waits for the FSM to reach its final state (`out2`), holds there for a programmed number of cycles, releases `a`, and confirms return to idle. It reports completion or timeout to the requesting logic. It sits between the MAC-side control logic and the FSM instance, and is the FSM's only driver of `a`.

## Interface
- `CNT_W`, 8: width of hold counter and `hold_cycles`
- `TIMEOUT`, 16: max cycles to wait for each FSM response; must be ≥ 2
- `RUN_W`, 16: width of completed-run counter

- `clk`  in  1  clock; all logic is rising-edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  request pulse; sampled only in IDLE
- `hold_cycles`  in  CNT_W  dwell in final state; latched on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on successful run
- `err`  out  1  one-cycle pulse on timeout
- `run_cnt`  out  RUN_W  successful runs, saturating
- `fsm_a`  out  1  drives the FSM `a` input
- `fsm_out1`  in  1  FSM intermediate-state indicator
- `fsm_out2`  in  1  FSM final-state indicator

## Operation
- Reset values: state IDLE; `busy`, `done`, `err`, `fsm_a` = 0; `run_cnt` = 0; timers cleared.
- IDLE: if `start`, latch `hold_cycles` into `hold_q`, clear timer, go to DRIVE.
- DRIVE: `fsm_a` = 1. If `fsm_out2` = 1, clear timer and go to HOLD. Otherwise increment timer; at timer = TIMEOUT-1, go to ERR.
- HOLD: `fsm_a` = 1. Count down `hold_q`. When it reaches 0, or if it was latched as 0, go to RELEASE.
- HOLD: if `fsm_out2` drops during HOLD, go to ERR.
- RELEASE: `fsm_a` = 0. If `fsm_out1` = 0 and `fsm_out2` = 0, go to DONE. Otherwise increment timer; at TIMEOUT-1, go to ERR.
- DONE: `done` = 1 for one cycle. Increment `run_cnt` unless it is all-ones. Go to IDLE.
- ERR: `err` = 1 for one cycle; `fsm_a` = 0. Go to IDLE. `run_cnt` is unchanged.
- `start` outside IDLE is ignored and not queued. `hold_cycles` is only sampled at acceptance.
- `done` and `err` are never high together.
- Outputs are registered, or decoded from registered state only. No combinational path from `fsm_*` to `fsm_a`.

## Timing
- Accepted `start` at edge N: `busy` and `fsm_a` are high from N+1.
- `fsm_out2` seen high at edge M in DRIVE: HOLD from M+1. With `hold_cycles` = H, RELEASE begins at M+1+max(H,1), so `fsm_a` is high exactly max(H,1) cycles in HOLD.
- Idle condition seen in RELEASE at edge R: `done` at R+1, `busy` low from R+2.
- Timeout: `err` is asserted TIMEOUT+1 cycles after entering DRIVE or RELEASE if no response arrives.
- `start` high in the same cycle as `done`/`err`: ignored, because the state is not IDLE.
- Back-to-back `start` is accepted one cycle after `busy` falls.
- `rst` mid-run: next cycle all outputs return to their reset values. `run_cnt` is cleared.

## Structure
- Package `fsm_ctrl_pkg`: state enum (`S_IDLE`, `S_DRIVE`, `S_HOLD`, `S_RELEASE`, `S_DONE`, `S_ERR`) and default parameter constants.
- Single module with one state register, one shared timeout counter (reused by DRIVE and RELEASE, cleared on state change), and one hold down-counter.
- Optional submodule `sat_counter` for `run_cnt`.

## Test plan
- Reset: assert `rst` 2 cycles, then release → all outputs 0, state IDLE.
- Nominal run, using a behavioural FSM model that raises `out2` 2 cycles after `a` and lowers `out1`/`out2` 1 cycle after `a` falls: `start` with `hold_cycles` = 3 → `fsm_a` high through HOLD for 3 cycles, `done` pulse, `run_cnt` = 1.
- DRIVE timeout: FSM model never raises `out2`, TIMEOUT = 16 → `err` pulse 17 cycles after DRIVE entry, `fsm_a` 0, `run_cnt` unchanged.
- HOLD loss: `out2` drops mid-hold → `err` next cycle, `fsm_a` = 0.
- `start` pulsed while busy, plus `hold_cycles` = 0 → second start ignored, HOLD lasts 1 cycle, a single `done`.
- Saturation and reset: with RUN_W = 2, run 5 times → `run_cnt` stays 3. Assert `rst` during DRIVE → `fsm_a` = 0 and `run_cnt` = 0 next cycle.
